// File: rtl/arm_mem_pkg.sv
// Shared types and helpers for the data-memory store buffer.
//
// Contents:
//   SB_DEPTH_DEFAULT  default number of store-buffer entries
//   SB_AW / SB_DW     address / data widths an entry is built for
//   sb_entry_t        one buffered store {word address, data}
//   word_addr()       byte address -> word address (drops bits [1:0])
package arm_mem_pkg;

    localparam int unsigned SB_DEPTH_DEFAULT = 4;
    localparam int unsigned SB_AW            = 32;
    localparam int unsigned SB_DW            = 32;
    localparam int unsigned SB_WAW           = SB_AW - 2;

    typedef struct packed {
        logic [SB_WAW-1:0] waddr;
        logic [SB_DW-1:0]  data;
    } sb_entry_t;

    function automatic logic [SB_WAW-1:0] word_addr(input logic [SB_AW-1:0] byte_addr);
        return byte_addr[SB_AW-1:2];
    endfunction

endpackage

// File: rtl/sb_match.sv
// Store-buffer address comparator.
//
// Compares a lookup word address against every entry and reports whether any
// valid entry matches, plus the index of the youngest matching entry.
// Validity and age are both pointer-relative: an entry's age offset is
// (index - rd_ptr) mod DEPTH, it is valid when that offset is below count,
// and a larger offset means a younger store.
//
// Ports:
//   entry_waddr   in   word address of every entry (index order)
//   rd_ptr        in   head (oldest) entry index
//   count         in   number of valid entries
//   lookup_waddr  in   word address being searched for
//   hit           out  at least one valid entry matches
//   hit_idx       out  index of the youngest matching entry (rd_ptr when no hit)
module sb_match #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WAW   = 30,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][WAW-1:0] entry_waddr,
    input  logic [PW-1:0]             rd_ptr,
    input  logic [PW:0]               count,
    input  logic [WAW-1:0]            lookup_waddr,
    output logic                      hit,
    output logic [PW-1:0]             hit_idx
);

    logic [PW-1:0] age;
    logic [PW-1:0] best_age;
    logic          valid;

    always_comb begin
        hit      = 1'b0;
        hit_idx  = rd_ptr;
        best_age = '0;
        age      = '0;
        valid    = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            // Modular subtraction wraps naturally because DEPTH is a power of two.
            age   = PW'(i) - rd_ptr;
            valid = {1'b0, age} < count;
            if (valid && (entry_waddr[i] == lookup_waddr) && (!hit || (age > best_age))) begin
                hit      = 1'b1;
                hit_idx  = PW'(i);
                best_age = age;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory responder for the pipelined core's memory stage.
//
// Stores are queued in a circular FIFO and drained to backing memory over a
// valid/ready write channel; loads read backing memory combinationally.
// Build option STORE_FWD_EN: when defined, loads that hit a buffered store
// return the youngest matching data; when undefined, such loads stall until
// the matching stores have drained.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   MemWriteM         store request          MemtoRegM   load request
//   ALUOutM           byte address           WriteDataM  store data
//   ReadDataM         load data (combinational)
//   StallSB           hold the M-stage request this cycle
//   SBEmpty           buffer empty
//   mem_wvalid/waddr/wdata/wready   head-entry write channel
//   mem_raddr/mem_rdata             combinational read port
module dmem_store_buffer
    import arm_mem_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
    parameter int unsigned AW    = SB_AW,
    parameter int unsigned DW    = SB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWriteM,
    input  logic          MemtoRegM,
    input  logic [AW-1:0] ALUOutM,
    input  logic [DW-1:0] WriteDataM,
    output logic [DW-1:0] ReadDataM,
    output logic          StallSB,
    output logic          SBEmpty,
    output logic          mem_wvalid,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_wready,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned WAW = AW - 2;

    // Entries are stored as sb_entry_t, so widths must match the package.
    if ((AW != SB_AW) || (DW != SB_DW) || (DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0))
    begin : g_bad_cfg
        $error("dmem_store_buffer: unsupported DEPTH/AW/DW combination");
    end

    sb_entry_t     entries_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    logic full, empty, enq, deq;
    logic hit;
    logic [PW-1:0] hit_idx;
    logic [DEPTH-1:0][WAW-1:0] entry_waddr;

    // count never exceeds DEPTH = 2**PW, so its MSB alone flags full.
    assign full  = count_q[PW];
    assign empty = (count_q == '0);
    assign enq   = MemWriteM && !full;
    assign deq   = !empty && mem_wready;

    assign SBEmpty    = empty;
    assign mem_wvalid = !empty;
    assign mem_waddr  = {entries_q[rd_ptr_q].waddr, 2'b00};
    assign mem_wdata  = entries_q[rd_ptr_q].data;
    assign mem_raddr  = ALUOutM;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
        if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload is qualified by the pointers/count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries_q[wr_ptr_q] <= '{waddr: word_addr(ALUOutM), data: WriteDataM};
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_waddr[i] = entries_q[i].waddr;
        end
    end

    sb_match #(
        .DEPTH (DEPTH),
        .WAW   (WAW)
    ) u_sb_match (
        .entry_waddr  (entry_waddr),
        .rd_ptr       (rd_ptr_q),
        .count        (count_q),
        .lookup_waddr (word_addr(ALUOutM)),
        .hit          (hit),
        .hit_idx      (hit_idx)
    );

    // Full test uses registered count: a same-cycle drain does not admit the store.
    always_comb begin
        ReadDataM = mem_rdata;
        StallSB   = MemWriteM && full;
`ifdef STORE_FWD_EN
        if (hit) ReadDataM = entries_q[hit_idx].data;
`else
        if (MemtoRegM && hit) StallSB = 1'b1;
`endif
    end

`ifdef STORE_FWD_EN
    logic unused_load_req;
    assign unused_load_req = MemtoRegM;
`else
    logic [PW-1:0] unused_hit_idx;
    assign unused_hit_idx = hit_idx;
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer (DEPTH 4, 32-bit address/data).
// A negedge monitor keeps a queue of accepted stores and checks the write
// channel, stall, empty and load data every cycle; directed checks cover the
// specific scenarios. Honours STORE_FWD_EN the same way the design does.
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;
    localparam logic [31:0] RKEY = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWriteM = 1'b0;
    logic        MemtoRegM = 1'b0;
    logic [31:0] ALUOutM = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] ReadDataM;
    logic        StallSB;
    logic        SBEmpty;
    logic        mem_wvalid;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wready = 1'b0;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata = '0;

    dmem_store_buffer #(
        .DEPTH (DEPTH),
        .AW    (32),
        .DW    (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallSB    (StallSB),
        .SBEmpty    (SBEmpty),
        .mem_wvalid (mem_wvalid),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    // Scoreboard monitor: model decisions use only the bench's own queue.
    logic        m_full, m_hit, m_stall;
    logic [31:0] m_fwd, m_rd;
    wr_t         m_new;

    always @(negedge clk) begin
        if (!reset) begin
            sb_q.delete();
            check("rst_wvalid", 32'(mem_wvalid), 32'd0);
            check("rst_empty", 32'(SBEmpty), 32'd1);
            check("rst_stall", 32'(StallSB), 32'd0);
        end else begin
            m_full = (sb_q.size() == DEPTH);
            m_hit  = 1'b0;
            m_fwd  = '0;
            foreach (sb_q[i]) begin
                if (sb_q[i].addr[31:2] == ALUOutM[31:2]) begin
                    m_hit = 1'b1;
                    m_fwd = sb_q[i].data;   // later entries are younger
                end
            end
`ifdef STORE_FWD_EN
            m_stall = MemWriteM && m_full;
            m_rd    = m_hit ? m_fwd : mem_rdata;
`else
            m_stall = (MemWriteM && m_full) || (MemtoRegM && m_hit);
            m_rd    = mem_rdata;
`endif
            check("mon_stall", 32'(StallSB), 32'(m_stall));
            check("mon_wvalid", 32'(mem_wvalid), 32'(sb_q.size() != 0));
            check("mon_empty", 32'(SBEmpty), 32'(sb_q.size() == 0));
            if (sb_q.size() != 0) begin
                check("mon_waddr", mem_waddr, {sb_q[0].addr[31:2], 2'b00});
                check("mon_wdata", mem_wdata, sb_q[0].data);
            end
            if (MemtoRegM && !MemWriteM) check("mon_rdata", ReadDataM, m_rd);
            if (mem_wready && sb_q.size() != 0) void'(sb_q.pop_front());
            if (MemWriteM && !m_full) begin
                m_new.addr = ALUOutM;
                m_new.data = WriteDataM;
                sb_q.push_back(m_new);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d);
        MemWriteM  = 1'b1;
        MemtoRegM  = 1'b0;
        ALUOutM    = a;
        WriteDataM = d;
    endtask

    task automatic drive_load(input logic [31:0] a);
        MemWriteM = 1'b0;
        MemtoRegM = 1'b1;
        ALUOutM   = a;
        mem_rdata = a ^ RKEY;
    endtask

    task automatic idle();
        MemWriteM = 1'b0;
        MemtoRegM = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc();
        check("reset_wvalid", 32'(mem_wvalid), 32'd0);
        check("reset_empty", 32'(SBEmpty), 32'd1);
        check("reset_stall", 32'(StallSB), 32'd0);
        cyc();
        reset = 1'b1;
        cyc();

        // Fill with the channel blocked, then a fifth store must stall
        mem_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            cyc();
        end
        drive_store(32'h110, 32'hA4);
        #2;
        check("full_stall", 32'(StallSB), 32'd1);
        check("head_addr", mem_waddr, 32'h100);
        check("head_data", mem_wdata, 32'hA0);
        cyc();
        #2;
        check("head_addr_hold", mem_waddr, 32'h100);
        check("full_stall_hold", 32'(StallSB), 32'd1);
        idle();

        // Drain four entries back to back
        mem_wready = 1'b1;
        repeat (4) cyc();
        mem_wready = 1'b0;
        #2;
        check("drained_empty", 32'(SBEmpty), 32'd1);
        check("drained_wvalid", 32'(mem_wvalid), 32'd0);
        cyc();

        // Two stores to one word, then loads
        drive_store(32'h200, 32'h11);
        cyc();
        drive_store(32'h200, 32'h22);
        cyc();
        drive_load(32'h300);
        #2;
        check("miss_rdata", ReadDataM, 32'h300 ^ RKEY);
        check("miss_stall", 32'(StallSB), 32'd0);
        check("raddr", mem_raddr, 32'h300);
        cyc();
        drive_load(32'h202);
        #2;
`ifdef STORE_FWD_EN
        check("fwd_rdata", ReadDataM, 32'h22);
        check("fwd_nostall", 32'(StallSB), 32'd0);
        cyc();
        idle();
        mem_wready = 1'b1;
        repeat (2) cyc();
`else
        check("hit_stall0", 32'(StallSB), 32'd1);
        cyc();
        check("hit_stall1", 32'(StallSB), 32'd1);
        mem_wready = 1'b1;
        cyc();
        #2;
        check("hit_stall_one_left", 32'(StallSB), 32'd1);
        cyc();
        #2;
        check("hit_released", 32'(StallSB), 32'd0);
        check("hit_rdata", ReadDataM, 32'h202 ^ RKEY);
        cyc();
        idle();
`endif
        mem_wready = 1'b0;
        #2;
        check("fwd_sect_empty", 32'(SBEmpty), 32'd1);
        cyc();

        // Full buffer with a same-cycle dequeue: store stalls, then is taken
        for (int i = 0; i < 4; i++) begin
            drive_store(32'h400 + 32'(4 * i), 32'hB0 + 32'(i));
            cyc();
        end
        drive_store(32'h410, 32'hB4);
        mem_wready = 1'b1;
        #2;
        check("simul_stall", 32'(StallSB), 32'd1);
        cyc();
        mem_wready = 1'b0;
        #2;
        check("simul_accept", 32'(StallSB), 32'd0);
        check("simul_head", mem_waddr, 32'h404);
        cyc();
        drive_store(32'h414, 32'hB5);
        #2;
        check("simul_refull", 32'(StallSB), 32'd1);
        cyc();
        idle();
        mem_wready = 1'b1;
        repeat (4) cyc();
        mem_wready = 1'b0;
        #2;
        check("simul_drained", 32'(SBEmpty), 32'd1);
        cyc();

        // Reset while three entries are waiting to drain
        for (int i = 0; i < 3; i++) begin
            drive_store(32'h500 + 32'(4 * i), 32'hC0 + 32'(i));
            cyc();
        end
        idle();
        mem_wready = 1'b1;
        #2;
        check("pre_rst_wvalid", 32'(mem_wvalid), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_wvalid", 32'(mem_wvalid), 32'd0);
        check("mid_rst_empty", 32'(SBEmpty), 32'd1);
        repeat (2) cyc();
        reset = 1'b1;
        repeat (4) cyc();
        check("post_rst_wvalid", 32'(mem_wvalid), 32'd0);
        check("post_rst_empty", 32'(SBEmpty), 32'd1);
        mem_wready = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Data-memory responder for the pipelined ARM core's memory-stage port (MemWriteM / ALUOutM / WriteDataM / ReadDataM). Gives the core a zero-latency word interface: stores are queued in a small FIFO and drained to a backing memory over a valid/ready write channel, while loads read the backing memory combinationally. Loads that hit a queued store are forwarded from the buffer. When the buffer is full, the block stalls the core's memory stage.

## Interface
- DEPTH, 4: store-buffer entries; power of two, at least 2
- AW, 32: address width (word-aligned byte address)
- DW, 32: data width
- clk  in  1  core clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- MemWriteM  in  1  store request this cycle
- MemtoRegM  in  1  load request this cycle
- ALUOutM  in  AW  byte address; bits [1:0] ignored
- WriteDataM  in  DW  store data
- ReadDataM  out  DW  load data, combinational
- StallSB  out  1  stall core M stage (hold request) this cycle
- SBEmpty  out  1  buffer empty (fence/drain indicator)
- mem_wvalid  out  1  head entry presented to backing memory
- mem_waddr  out  AW  head address
- mem_wdata  out  DW  head data
- mem_wready  in  1  backing memory accepts head
- mem_raddr  out  AW  load address (= ALUOutM)
- mem_rdata  in  DW  backing-memory combinational read data

## Operation
- Circular FIFO: wr_ptr, rd_ptr (log2 DEPTH bits) and count (log2 DEPTH + 1 bits).
- full = (count == DEPTH); empty = (count == 0); SBEmpty = empty.
- Enqueue: MemWriteM && !full writes {ALUOutM[AW-1:2], WriteDataM} at wr_ptr; wr_ptr increments with wrap.
- Store stall: StallSB = MemWriteM && full. The full test uses the registered count, so a same-cycle dequeue does not free a slot for that cycle's store.
- Dequeue: mem_wvalid = !empty, and mem_waddr/mem_wdata come from the head entry. On mem_wvalid && mem_wready, rd_ptr increments with wrap.
- count update: +1 on enqueue only, −1 on dequeue only, unchanged when both or neither occur.
- Loads:
  - mem_raddr = ALUOutM always.
  - ReadDataM = mem_rdata unless overridden by forwarding (see Configuration).
  - Address match compares word address bits [AW-1:2] only, and only against valid entries (those between rd_ptr and wr_ptr).
- Simultaneous MemWriteM and MemtoRegM is a protocol error. The store takes effect and ReadDataM is don't-care.
- Head entry outputs stay stable while mem_wvalid is high and mem_wready is low.

## Timing
- Reset (asynchronous assert, synchronous-release safe): pointers = 0, count = 0, all entries' valid-qualification cleared.
  - Outputs during reset: mem_wvalid = 0, SBEmpty = 1, StallSB = 0.
  - Entry payload is not reset.
- Reset mid-drain: all queued stores are discarded, and mem_wvalid drops immediately.
- Store to mem_wvalid: an enqueue at edge N makes the entry visible on mem_wvalid in cycle N+1 if the buffer was empty.
- Load latency: 0 cycles. ReadDataM is combinational from ALUOutM, the entries and mem_rdata.
- Store-then-load to the same word in the next cycle returns the new data via forwarding.
- Drain throughput: 1 entry per cycle when mem_wready is held high.
- StallSB is combinational and asserts in the same cycle as the offending request.

## Configuration
- STORE_FWD_EN defined:
  - A load matching one or more buffered entries returns WriteDataM of the youngest match (closest to wr_ptr − 1).
  - StallSB is never asserted for loads.
- STORE_FWD_EN undefined:
  - No forwarding mux.
  - A load matching any valid entry asserts StallSB until no valid entry matches. StallSB = (MemWriteM && full) || (MemtoRegM && hit).
  - ReadDataM = mem_rdata always.

## Structure
- Package arm_mem_pkg holds:
  - SB_DEPTH_DEFAULT
  - sb_entry_t struct {word address, data}
  - word-address helper function
- Sub-module sb_match (natural split): a parameterised comparator over all entries. It produces a hit flag and the youngest-match index, using pointer-relative age ordering.
- Top level holds the FIFO storage, pointers, count, handshake and stall logic.

## Test plan
- Reset, then 4 stores (addr 0x100..0x10C, data 0xA0..0xA3) with mem_wready = 0 → count = 4. A 5th store asserts StallSB in the same cycle. mem_waddr = 0x100 held stable.
- Release mem_wready for 4 cycles → writes drain in order 0xA0..0xA3. SBEmpty = 1 after the last handshake. mem_wvalid = 0.
- With STORE_FWD_EN: store 0x11 to 0x200, then 0x22 to 0x200 (mem_wready = 0); load 0x202 → ReadDataM = 0x22. A load of 0x300 returns mem_rdata.
- Without STORE_FWD_EN: same store sequence, load 0x200 → StallSB = 1 until both entries drain, then ReadDataM = mem_rdata.
- Full buffer with a simultaneous store and dequeue handshake → store stalls that cycle and is accepted the next cycle. count goes 4 → 3 → 4.
- Assert reset mid-drain with 3 entries queued → mem_wvalid = 0 and SBEmpty = 1 immediately. After release, no stale write appears.
